// File: rtl/led_display_pkg.sv
// Shared definitions for the eight-digit seven-segment display controller:
// source-select encodings, active-low segment patterns and blanking constants.
package led_display_pkg;

  // Which CPU value the display frame is built from
  typedef enum logic [1:0] {
    DISP_SEL_SYSCALL = 2'd0,
    DISP_SEL_CYCLES  = 2'd1,
    DISP_SEL_CONDI   = 2'd2,
    DISP_SEL_UNCONDI = 2'd3
  } dispSel_e;

  localparam int NUM_DIGITS = 8;

  // All cathodes and anodes are active-low, so all-ones means dark
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Segment patterns {dp,g,f,e,d,c,b,a}, active-low, decimal point off
  localparam logic [7:0] SEG_HEX_0 = 8'hC0;
  localparam logic [7:0] SEG_HEX_1 = 8'hF9;
  localparam logic [7:0] SEG_HEX_2 = 8'hA4;
  localparam logic [7:0] SEG_HEX_3 = 8'hB0;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h92;
  localparam logic [7:0] SEG_HEX_6 = 8'h82;
  localparam logic [7:0] SEG_HEX_7 = 8'hF8;
  localparam logic [7:0] SEG_HEX_8 = 8'h80;
  localparam logic [7:0] SEG_HEX_9 = 8'h90;
  localparam logic [7:0] SEG_HEX_A = 8'h88;
  localparam logic [7:0] SEG_HEX_B = 8'h83;
  localparam logic [7:0] SEG_HEX_C = 8'hC6;
  localparam logic [7:0] SEG_HEX_D = 8'hA1;
  localparam logic [7:0] SEG_HEX_E = 8'h86;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

  // One-hot active-low anode pattern for a digit index
  function automatic logic [7:0] digitAnode(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/led_display_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
  import led_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_seg
);

  // Look up the segment pattern for the nibble; the dp bit stays dark
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_HEX_0;
      4'h1: o_seg = SEG_HEX_1;
      4'h2: o_seg = SEG_HEX_2;
      4'h3: o_seg = SEG_HEX_3;
      4'h4: o_seg = SEG_HEX_4;
      4'h5: o_seg = SEG_HEX_5;
      4'h6: o_seg = SEG_HEX_6;
      4'h7: o_seg = SEG_HEX_7;
      4'h8: o_seg = SEG_HEX_8;
      4'h9: o_seg = SEG_HEX_9;
      4'hA: o_seg = SEG_HEX_A;
      4'hB: o_seg = SEG_HEX_B;
      4'hC: o_seg = SEG_HEX_C;
      4'hD: o_seg = SEG_HEX_D;
      4'hE: o_seg = SEG_HEX_E;
      4'hF: o_seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/led_display_ctrl.sv
// Eight-digit multiplexed seven-segment display controller for the CPU.
// A syscall latch holds the last value the CPU printed; a frame snapshot of
// the selected source is taken once per full scan so a frame never mixes
// old and new digits. Digits are scanned LSB nibble first, SCAN_DIV clocks
// each, with anode/segment outputs registered one clock behind the index.
// Optional build macro LED_DISPLAY_LZB_EN enables leading-zero blanking
// (digit 0 always stays lit); without it all eight digits are always lit.
module led_display_ctrl
  import led_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_cpu_enable,
  input  logic [31:0] led_data_in,
  input  logic [31:0] total_cycles,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] uncondi_branch_num,
  input  logic [1:0]  disp_sel,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        led_valid
);

  localparam int               CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [31:0]      r_latch;
  logic             r_valid;
  logic [31:0]      r_snapshot;
  logic [CNT_W-1:0] r_scanCnt;
  logic [2:0]       r_digit;
  logic [7:0]       r_an;
  logic [7:0]       r_seg;

  logic             w_scanLast;
  logic             w_frameWrap;
  logic             w_firstLoad;
  logic [31:0]      w_selSource;
  logic [31:0]      w_freshSource;
  logic [3:0]       w_nibble;
  logic [7:0]       w_segCode;
  logic             w_digitBlank;

  assign w_scanLast  = (r_scanCnt == CNT_LAST);
  assign w_frameWrap = w_scanLast && (r_digit == 3'(NUM_DIGITS - 1));
  assign w_firstLoad = led_cpu_enable && !r_valid;
  assign w_nibble    = r_snapshot[{r_digit, 2'b00} +: 4];

`ifdef LED_DISPLAY_LZB_EN
  assign w_digitBlank = (r_digit != 3'd0) && ((r_snapshot >> {r_digit, 2'b00}) == 32'd0);
`else
  assign w_digitBlank = 1'b0;
`endif

  // Pick the frame source; the fresh variant feeds the first syscall value straight through
  always_comb begin
    w_selSource   = r_latch;
    w_freshSource = led_data_in;
    case (dispSel_e'(disp_sel))
      DISP_SEL_CYCLES: begin
        w_selSource   = total_cycles;
        w_freshSource = total_cycles;
      end
      DISP_SEL_CONDI: begin
        w_selSource   = condi_branch_num;
        w_freshSource = condi_branch_num;
      end
      DISP_SEL_UNCONDI: begin
        w_selSource   = uncondi_branch_num;
        w_freshSource = uncondi_branch_num;
      end
      default: ;
    endcase
  end

  // Syscall latch reloads on every strobe cycle; valid sticks until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_latch <= '0;
      r_valid <= 1'b0;
    end else if (led_cpu_enable) begin
      r_latch <= led_data_in;
      r_valid <= 1'b1;
    end
  end

  // Frame snapshot: scan wrap wins and takes the pre-load latch; otherwise grab the first value early
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snapshot <= '0;
    end else if (w_frameWrap) begin
      r_snapshot <= w_selSource;
    end else if (w_firstLoad) begin
      r_snapshot <= w_freshSource;
    end
  end

  // Dwell counter per digit and the digit index it advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scanCnt <= '0;
      r_digit   <= '0;
    end else if (w_scanLast) begin
      r_scanCnt <= '0;
      r_digit   <= r_digit + 3'd1;
    end else begin
      r_scanCnt <= r_scanCnt + 1'b1;
    end
  end

  // Registered anode/segment drive, dark during reset and for blanked digits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else if (w_digitBlank) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= digitAnode(r_digit);
      r_seg <= w_segCode;
    end
  end

  hex_to_seg u_hexToSeg (
    .i_nibble (w_nibble),
    .o_seg    (w_segCode)
  );

  assign an        = r_an;
  assign seg       = r_seg;
  assign led_valid = r_valid;

endmodule
